// File: rtl/npc_bus_pkg.sv
// Shared types for the NPC memory arbiter: FSM states, master ids, default widths.
package npc_bus_pkg;

  localparam int unsigned NpcAddrW      = 32;
  localparam int unsigned NpcDataW      = 32;
  localparam int unsigned NpcRspTimeout = 255;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    MST_IFU,
    MST_LSU
  } master_id_t;

  // The master that did not win last time.
  function automatic master_id_t other_master(input master_id_t m);
    return (m == MST_IFU) ? MST_LSU : MST_IFU;
  endfunction

endpackage

// File: rtl/npc_arb_pick.sv
// Combinational winner selection between IFU and LSU.
// On a tie the master not granted last wins; the top feeds a constant
// last-grant of IFU when NPC_ARB_ROUND_ROBIN_EN is undefined, which yields
// fixed LSU priority.
module npc_arb_pick
  import npc_bus_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  master_id_t last_grant_i,
  output logic       grant_valid_o,
  output master_id_t grant_o
);

  // Single requester wins outright; a tie alternates against last_grant_i.
  always_comb begin
    grant_valid_o = ifu_valid_i | lsu_valid_i;
    grant_o       = MST_LSU;
    if (ifu_valid_i && lsu_valid_i) begin
      grant_o = other_master(last_grant_i);
    end else if (ifu_valid_i) begin
      grant_o = MST_IFU;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port. One transaction at
// a time: IDLE (accept) -> REQ (hold until mem ready) -> WAIT (response or
// timeout) -> RESP (one-cycle registered response pulse to the owner).
// Optional feature: define NPC_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise the LSU has fixed priority.
module npc_mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = NpcAddrW,
  parameter int unsigned DATA_W      = NpcDataW,
  parameter int unsigned RSP_TIMEOUT = NpcRspTimeout
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,

  output logic              busy
);

  // Counter only needs to reach RSP_TIMEOUT-1.
  localparam int unsigned CntW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RSP_TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  master_id_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic       grant_valid;
  master_id_t grant;
  master_id_t pick_last;
  logic       accept;

`ifdef NPC_ARB_ROUND_ROBIN_EN
  master_id_t last_grant_q, last_grant_d;

  // Remember the winner of every accept for tie alternation.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant;
    end
  end

  // Last-grant register; resets to LSU so the IFU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= MST_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign pick_last = last_grant_q;
`else
  // Pretending the IFU always won last makes every tie go to the LSU.
  assign pick_last = MST_IFU;
`endif

  npc_arb_pick u_pick (
    .ifu_valid_i   (ifu_req_valid),
    .lsu_valid_i   (lsu_req_valid),
    .last_grant_i  (pick_last),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  // Readies are forced low while reset is asserted.
  assign accept        = (state_q == IDLE) && rst && grant_valid;
  assign ifu_req_ready = accept && (grant == MST_IFU);
  assign lsu_req_ready = accept && (grant == MST_LSU);

  // Next-state and latched-field updates.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          state_d = REQ;
          if (grant == MST_IFU) begin
            // IFU is read-only.
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end else begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response beats the timeout in the same cycle.
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CntLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request/response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= MST_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign ifu_rsp_valid = (state_q == RESP) && (owner_q == MST_IFU);
  assign lsu_rsp_valid = (state_q == RESP) && (owner_q == MST_LSU);
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;
  assign ifu_rsp_data  = data_q;
  assign lsu_rsp_data  = data_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed self-checking bench for npc_mem_arbiter (RSP_TIMEOUT = 4).
module tb_npc_mem_arbiter;
  import npc_bus_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rsp_data;
  logic [7:0]    lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [7:0]    mem_wmask;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  npc_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .RSP_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic       exp_ifu;
  logic [8:0] exp_wm;

  initial begin
    clear_inputs();
    rst = 1'b0;
    ifu_req_valid = 1'b1;  // readies must stay low under reset
    #2;
    check("rst_ctrl", {busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid,
                       lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err, mem_wen, mem_wmask}, 64'h0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_data", {mem_wdata, ifu_rsp_data}, 64'h0);
    ifu_req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Memory response outside WAIT is ignored.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    check("stray_rsp", {busy, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);

    // IFU read alone.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    #1;
    check("ifu_rdy", {ifu_req_ready, lsu_req_ready}, 64'h2);
    step();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'hFFFF_FFFF;
    check("ifu_req_valid", mem_req_valid, 64'h1);
    check("ifu_req_addr", mem_addr, 64'h8000_0000);
    check("ifu_req_ro", {mem_wen, mem_wmask, ifu_req_ready}, 64'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("ifu_wait", {mem_req_valid, busy}, 64'h1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0010_0093;
    step();
    mem_rsp_valid = 1'b0;
    check("ifu_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 64'h4);
    check("ifu_rsp_data", ifu_rsp_data, 64'h0010_0093);
    step();
    check("ifu_done", {ifu_rsp_valid, lsu_rsp_valid, busy}, 64'h0);

    // LSU write with mem_req_ready delayed 3 cycles.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1004;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 8'h0F;
    #1;
    check("lsu_rdy", {ifu_req_ready, lsu_req_ready}, 64'h1);
    step();
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("lsu_hold_addr", mem_addr, 64'h8000_1004);
      check("lsu_hold_fields", {mem_req_valid, mem_wen, mem_wmask, mem_wdata},
            {22'h0, 1'b1, 1'b1, 8'h0F, 32'hDEAD_BEEF});
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    check("lsu_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 64'h4);
    step();
    check("lsu_rsp_pulse", {lsu_rsp_valid, busy}, 64'h0);

    // Four transactions with both masters requesting.
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hCAFE_F00D;
    lsu_wmask     = 8'hFF;
    for (int t = 0; t < 4; t++) begin
`ifdef NPC_ARB_ROUND_ROBIN_EN
      exp_ifu = (t % 2 == 0);
`else
      exp_ifu = 1'b0;
`endif
      exp_wm = exp_ifu ? 9'h000 : 9'h1FF;
      #1;
      check("tie_grant", {ifu_req_ready, lsu_req_ready}, {62'h0, exp_ifu, ~exp_ifu});
      step();
      check("tie_wen_mask", {mem_wen, mem_wmask}, {55'h0, exp_wm});
      check("tie_busy_rdy", {ifu_req_ready, lsu_req_ready}, 64'h0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_0100 + 32'(t);
      step();
      mem_rsp_valid = 1'b0;
      check("tie_owner", {ifu_rsp_valid, lsu_rsp_valid}, {62'h0, exp_ifu, ~exp_ifu});
      check("tie_data", lsu_rsp_data, 64'h100 + 64'(t));
      step();
    end
    clear_inputs();

    // Timeout: no response for TO WAIT cycles.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0200;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      check("to_wait", {busy, ifu_rsp_valid}, 64'h2);
      step();
    end
    check("to_rsp", {ifu_rsp_valid, ifu_rsp_err}, 64'h3);
    check("to_data", ifu_rsp_data, 64'h0);
    step();
    check("to_idle", {busy, ifu_rsp_valid, ifu_rsp_err}, 64'h0);

    // Response on the final timeout cycle wins.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_0400;
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      if (i == int'(TO) - 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
      end
      step();
    end
    mem_rsp_valid = 1'b0;
    check("race_rsp", {lsu_rsp_valid, lsu_rsp_err}, 64'h2);
    check("race_data", lsu_rsp_data, 64'h1234_5678);
    step();

    // Reset during an LSU read in WAIT, then a fresh IFU read.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_0500;
    lsu_wen       = 1'b0;
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0300;
    rst = 1'b0;
    #1;
    check("rstw_ctrl", {busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid,
                        lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err, mem_wen, mem_wmask}, 64'h0);
    check("rstw_addr", mem_addr, 64'h0);
    check("rstw_data", {mem_wdata, lsu_rsp_data}, 64'h0);
    step();
    rst = 1'b1;
    #1;
    check("rstw_ifu_rdy", {ifu_req_ready, lsu_rsp_valid}, 64'h2);
    step();
    ifu_req_valid = 1'b0;
    check("rstw_req", mem_addr, 64'h8000_0300);
    check("rstw_no_lsu1", lsu_rsp_valid, 64'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rstw_no_lsu2", lsu_rsp_valid, 64'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hABCD_0001;
    step();
    mem_rsp_valid = 1'b0;
    check("rstw_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 64'h4);
    check("rstw_rsp_data", ifu_rsp_data, 64'hABCD_0001);
    step();
    check("rstw_done", {busy, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
